// File: rtl/taillight_sequencer_pkg.sv
// Shared tail-light types: mode encodings, lamp phase patterns and request decode.
// Pure declarations, no timing; backpressure: none.
package taillight_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_t;

  typedef logic [1:0] phase_t;

  localparam logic [2:0] PAT_P0    = 3'b000;
  localparam logic [2:0] PAT_P1    = 3'b001;
  localparam logic [2:0] PAT_P2    = 3'b011;
  localparam logic [2:0] PAT_P3    = 3'b111;
  localparam logic [2:0] LAMPS_ON  = 3'b111;
  localparam logic [2:0] LAMPS_OFF = 3'b000;

  function automatic logic [2:0] phase_pattern(input phase_t ph);
    logic [2:0] pat;
    pat = PAT_P0;
    case (ph)
      2'd0:    pat = PAT_P0;
      2'd1:    pat = PAT_P1;
      2'd2:    pat = PAT_P2;
      default: pat = PAT_P3;
    endcase
    return pat;
  endfunction

  // Hazard dominates; conflicting left+right falls back to idle.
  function automatic mode_t requested_mode(input logic left, input logic right,
                                           input logic hazard);
    mode_t m;
    m = MODE_IDLE;
    if (hazard)              m = MODE_HAZARD;
    else if (left && !right) m = MODE_LEFT;
    else if (right && !left) m = MODE_RIGHT;
    return m;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Counts tick pulses and flags a step on the STEP_TICKS-th tick (combinational step).
// Latency: step asserted in the same cycle as the qualifying tick; backpressure: none.
module step_timer #(
  parameter int unsigned STEP_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  output logic step
);

  localparam logic [7:0] LAST_COUNT = 8'(STEP_TICKS - 1);

  logic [7:0] tick_cnt;

  assign step = tick && (tick_cnt == LAST_COUNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= 8'd0;
    end else if (tick) begin
      tick_cnt <= step ? 8'd0 : tick_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/taillight_sequencer.sv
// Turn/hazard/brake tail-light sequencer; mode and phase change only on step events.
// Latency: leds follow mode/phase/brake registers by 1 cycle; backpressure: none.
module taillight_sequencer
  import taillight_sequencer_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_hazard,
  input  logic       req_brake,
  output logic [2:0] left_leds,
  output logic [2:0] right_leds,
  output logic [1:0] mode,
  output logic       step_done
);

  logic       step;
  mode_t      mode_q, mode_d, req_mode;
  phase_t     phase_q, phase_d;
  logic       brake_q;
  logic [2:0] pat;
  logic [2:0] bank_fill;
  logic [2:0] left_d, right_d;

  step_timer #(
    .STEP_TICKS(STEP_TICKS)
  ) u_step_timer (
    .clock(clock),
    .reset(reset),
    .tick (tick),
    .step (step)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q     <= MODE_IDLE;
      phase_q    <= 2'd0;
      brake_q    <= 1'b0;
      left_leds  <= LAMPS_OFF;
      right_leds <= LAMPS_OFF;
      step_done  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      brake_q    <= req_brake;
      left_leds  <= left_d;
      right_leds <= right_d;
      step_done  <= step;
    end
  end

  // A mode change restarts the sweep at P0; idle never leaves P0.
  always_comb begin
    mode_d   = mode_q;
    phase_d  = phase_q;
    req_mode = requested_mode(req_left, req_right, req_hazard);
    if (step) begin
      if (req_mode != mode_q) begin
        mode_d  = req_mode;
        phase_d = 2'd0;
      end else if (mode_q == MODE_IDLE) begin
        phase_d = 2'd0;
      end else begin
        phase_d = phase_q + 2'd1;
      end
    end
  end

  // Non-blinking banks act as brake lamps; hazard with brake lights everything.
  always_comb begin
    pat       = phase_pattern(phase_q);
    bank_fill = brake_q ? LAMPS_ON : LAMPS_OFF;
    left_d    = bank_fill;
    right_d   = bank_fill;
    case (mode_q)
      MODE_LEFT:   left_d  = pat;
      MODE_RIGHT:  right_d = pat;
      MODE_HAZARD: begin
        if (!brake_q) begin
          left_d  = pat;
          right_d = pat;
        end
      end
      default: ;
    endcase
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_taillight_sequencer.sv
// Bench for taillight_sequencer: two instances (STEP_TICKS 4 and 1) on shared stimulus.
module tb_taillight_sequencer;

  logic       clock = 1'b0;
  logic       reset, tick, req_left, req_right, req_hazard, req_brake;
  logic [2:0] l4, r4, l1, r1;
  logic [1:0] m4, m1;
  logic       sd4, sd1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] l;
    logic [2:0] r;
    logic [1:0] m;
    logic       sd;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  // Reference state per instance: index 0 -> STEP_TICKS=4, index 1 -> STEP_TICKS=1.
  int         st[2] = '{4, 1};
  int         cnt[2], md[2], ph[2];
  bit         brk[2];
  logic [2:0] el[2], er[2];
  bit         esd[2];

  always #5 clock = ~clock;

  taillight_sequencer #(.STEP_TICKS(4)) dut4 (
    .clock(clock), .reset(reset), .tick(tick),
    .req_left(req_left), .req_right(req_right), .req_hazard(req_hazard), .req_brake(req_brake),
    .left_leds(l4), .right_leds(r4), .mode(m4), .step_done(sd4)
  );

  taillight_sequencer #(.STEP_TICKS(1)) dut1 (
    .clock(clock), .reset(reset), .tick(tick),
    .req_left(req_left), .req_right(req_right), .req_hazard(req_hazard), .req_brake(req_brake),
    .left_leds(l1), .right_leds(r1), .mode(m1), .step_done(sd1)
  );

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs currently driven.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [2:0] pat;
      bit         stp;
      int         rq;
      if (reset) begin
        cnt[i] = 0; md[i] = 0; ph[i] = 0; brk[i] = 0;
        el[i] = 3'b000; er[i] = 3'b000; esd[i] = 0;
      end else begin
        pat   = 3'((1 << ph[i]) - 1);
        el[i] = brk[i] ? 3'b111 : 3'b000;
        er[i] = el[i];
        if (md[i] == 1 || (md[i] == 3 && !brk[i])) el[i] = pat;
        if (md[i] == 2 || (md[i] == 3 && !brk[i])) er[i] = pat;
        stp    = tick && (cnt[i] == st[i] - 1);
        esd[i] = stp;
        if (tick) cnt[i] = stp ? 0 : cnt[i] + 1;
        if (stp) begin
          rq = req_hazard ? 3 : (req_left && !req_right) ? 1 : (req_right && !req_left) ? 2 : 0;
          if (rq != md[i]) begin
            md[i] = rq;
            ph[i] = 0;
          end else if (md[i] != 0) begin
            ph[i] = (ph[i] + 1) % 4;
          end
        end
        brk[i] = req_brake;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_edge();
    e.l = el[0]; e.r = er[0]; e.m = 2'(md[0]); e.sd = esd[0];
    q4.push_back(e);
    e.l = el[1]; e.r = er[1]; e.m = 2'(md[1]); e.sd = esd[1];
    q1.push_back(e);
    @(posedge clock);
    #1;
    e = q4.pop_front();
    check("sb4_left",  l4,  e.l);
    check("sb4_right", r4,  e.r);
    check("sb4_mode",  {1'b0, m4}, {1'b0, e.m});
    check("sb4_step",  {2'b0, sd4}, {2'b0, e.sd});
    e = q1.pop_front();
    check("sb1_left",  l1,  e.l);
    check("sb1_right", r1,  e.r);
    check("sb1_mode",  {1'b0, m1}, {1'b0, e.m});
    check("sb1_step",  {2'b0, sd1}, {2'b0, e.sd});
  endtask

  // Runs at least one cycle, then until the STEP_TICKS=4 instance pulses step_done.
  task automatic wait_step(input string tag);
    int n;
    cycle();
    n = 1;
    while (sd4 !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < 20) else begin
      errors++;
      $error("FAIL %s step_done timeout observed_cycles=%0d expected_below=20", tag, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b1;
    req_left = 1'b1; req_right = 1'b0; req_hazard = 1'b0; req_brake = 1'b0;
    cycle();
    cycle();
    check("rst_left", l4, 3'b000);
    check("rst_mode", {1'b0, m4}, 3'd0);
    reset = 1'b0;

    // Left sweep at 4-cycle step intervals.
    begin
      logic [2:0] left_seq[5];
      left_seq = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
      for (int k = 0; k < 5; k++) begin
        wait_step("left_seq");
        cycle();
        check("left_seq_left", l4, left_seq[k]);
        check("left_seq_right", r4, 3'b000);
        check("left_seq_mode", {1'b0, m4}, 3'd1);
      end
    end

    // Right sweep, then hazard requested while at P2.
    req_left = 1'b0; req_right = 1'b1;
    wait_step("right_p0"); cycle();
    check("right_p0_mode", {1'b0, m4}, 3'd2);
    check("right_p0", r4, 3'b000);
    wait_step("right_p1"); cycle();
    check("right_p1", r4, 3'b001);
    wait_step("right_p2"); cycle();
    check("right_p2", r4, 3'b011);
    check("right_p2_left", l4, 3'b000);
    req_hazard = 1'b1;
    wait_step("haz_p0"); cycle();
    check("haz_p0_mode", {1'b0, m4}, 3'd3);
    check("haz_p0_left", l4, 3'b000);
    check("haz_p0_right", r4, 3'b000);
    wait_step("haz_p1"); cycle();
    check("haz_p1_left", l4, 3'b001);
    check("haz_p1_right", r4, 3'b001);
    wait_step("haz_p2"); cycle();
    check("haz_p2_left", l4, 3'b011);
    check("haz_p2_right", r4, 3'b011);
    wait_step("haz_p3"); cycle();
    check("haz_p3_left", l4, 3'b111);

    // Reset in the middle of hazard P3.
    reset = 1'b1;
    cycle();
    check("midrst_left", l4, 3'b000);
    check("midrst_right", r4, 3'b000);
    check("midrst_mode", {1'b0, m4}, 3'd0);
    check("midrst_step", {2'b0, sd4}, 3'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("post_rst_no_step", {2'b0, sd4}, 3'd0);
    end
    cycle();
    check("post_rst_step4", {2'b0, sd4}, 3'd1);

    // Brake pulse while turning left.
    req_hazard = 1'b0; req_right = 1'b0; req_left = 1'b1;
    wait_step("to_left");
    req_brake = 1'b1;
    cycle(); check("brk_c0", r4, 3'b000);
    cycle(); check("brk_c1", r4, 3'b111);
    cycle(); check("brk_c2", r4, 3'b111);
    req_brake = 1'b0;
    cycle(); check("brk_c3", r4, 3'b111);
    cycle(); check("brk_c4", r4, 3'b000);

    // Conflicting turn requests fall back to idle.
    req_right = 1'b1;
    wait_step("both"); cycle();
    check("both_mode", {1'b0, m4}, 3'd0);
    check("both_left", l4, 3'b000);
    check("both_right", r4, 3'b000);
    req_brake = 1'b1;
    cycle(); cycle();
    check("both_brk_left", l4, 3'b111);
    check("both_brk_right", r4, 3'b111);

    // Sparse ticks: the STEP_TICKS=1 instance steps on every tick.
    req_brake = 1'b0; req_right = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick = 1'b1;
      cycle();
      check("st1_step_after_tick", {2'b0, sd1}, 3'd1);
      tick = 1'b0;
      cycle();
      check("st1_idle_cycle", {2'b0, sd1}, 3'd0);
    end
    check("st1_mode", {1'b0, m1}, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/taillight_sequencer.md
TAILLIGHT_SEQUENCER -- requirements
Module: taillight_sequencer

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 4: tick pulses per pattern step, legal range 1..255.
REQ-002 SHALL have port clock, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port tick, input, 1: one-cycle enable pulse from the clock divider.
REQ-005 SHALL have port req_left, input, 1: left-turn request, level.
REQ-006 SHALL have port req_right, input, 1: right-turn request, level.
REQ-007 SHALL have port req_hazard, input, 1: hazard request, level.
REQ-008 SHALL have port req_brake, input, 1: brake request, level.
REQ-009 SHALL have port left_leds, output, 3: left lamp bank; bit0 innermost, registered.
REQ-010 SHALL have port right_leds, output, 3: right lamp bank; bit0 innermost, registered.
REQ-011 SHALL have port mode, output, 2: current mode; IDLE=0, LEFT=1, RIGHT=2, HAZARD=3.
REQ-012 SHALL have port step_done, output, 1: one-cycle pulse on every pattern step.

Function
REQ-013 SHALL hold an 8-bit tick counter; a step event occurs on the cycle tick=1 with counter=STEP_TICKS-1; counter then wraps to 0; tick=0 holds counter.
REQ-014 SHALL hold a 2-bit phase; patterns P0..P3 = 000, 001, 011, 111; phase advances P3->P0 on wrap.
REQ-015 SHALL derive the requested mode as: hazard -> HAZARD; else left and not right -> LEFT; else right and not left -> RIGHT; else (none or both) -> IDLE.
REQ-016 SHALL update mode only on a step event; if the requested mode differs from the current mode, mode takes the new value and phase goes to P0; otherwise phase advances.
REQ-017 SHALL, in IDLE, hold phase at P0.
REQ-018 SHALL drive the blinking bank(s) with the phase pattern: LEFT -> left bank; RIGHT -> right bank; HAZARD -> both banks, identical phase.
REQ-019 SHALL drive a non-blinking bank with 111 when req_brake=1 and 000 otherwise; IDLE with brake gives 111 on both banks.
REQ-020 SHALL drive both banks with 111 in HAZARD when req_brake=1.
REQ-021 SHALL register req_brake once, so brake changes reach the outputs exactly 1 cycle later, independent of the step event.
REQ-022 SHALL register left_leds and right_leds, giving a 1-cycle latency from the mode/phase/brake-register update to the outputs.
REQ-023 SHALL assert step_done during the cycle after each step event, for 1 cycle.
REQ-024 SHALL, on tick coincident with a request change, apply the change and step in that same step event, with no skipped or extra step.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, set the following and hold them while reset=1: mode=IDLE, phase=P0, tick counter=0, brake register=0, left_leds=000, right_leds=000, step_done=0.
REQ-026 SHALL take priority over tick and all requests when reset is asserted mid-sequence; the first step event after release occurs on the STEP_TICKS-th tick.

Structure
REQ-027 SHALL take the mode encodings and P0..P3 pattern constants from the shared tail-light package; this package is also used by the top-level and the blink logic.
REQ-028 SHALL use one sub-module, step_timer: tick counter and step event generation, parameterised by STEP_TICKS.
REQ-029 SHALL be 120-400 lines of RTL with no latches; all outputs come from flops.

Verification
REQ-030 SHALL cover: STEP_TICKS=4, tick every cycle, req_left=1 -> left_leds 000,001,011,111,000 at step intervals of 4 cycles; right_leds=000; mode=1.
REQ-031 SHALL cover: req_right=1 then req_hazard=1 at phase P2 -> next step gives mode=3, both banks 000, then 001, 011 in lockstep.
REQ-032 SHALL cover: mode=LEFT, req_brake pulsed 1 for 3 cycles -> right_leds=111 for exactly 3 cycles starting 1 cycle later; left pattern unaffected.
REQ-033 SHALL cover: req_left=1 and req_right=1 together -> mode=0, both banks 000; with req_brake=1 -> both banks 111.
REQ-034 SHALL cover: reset=1 mid-phase P3 in HAZARD -> next cycle all outputs 0 and mode=0; after release, the first step_done follows the 4th tick.
REQ-035 SHALL cover: STEP_TICKS=1, tick every other cycle -> one step per tick; step_done asserted one cycle after each tick.
